// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to packed BCD converter.
// Ports: clk, nrst (async low), start/bin in; busy, done, ovf, number out.
// Optional macro LZ_BLANK_EN replaces leading zero digits with BLANK_CODE.
module bin2bcd_seq #(
    parameter int         BIN_W      = 14,
    parameter int         DIGITS     = 4,
    parameter int         MAX_VAL    = 9999,
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   number
);

    localparam int NUM_W = 4 * DIGITS;
    localparam int SR_W  = NUM_W + BIN_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);

    function automatic logic [NUM_W-1:0] to_bcd(input int v);
        logic [NUM_W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    localparam logic [NUM_W-1:0] SAT_BCD = to_bcd(MAX_VAL);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_adj;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_n;
    logic [NUM_W-1:0]  bcd_raw;
    logic [NUM_W-1:0]  bcd_out;

    assign busy    = (state != IDLE);
    assign bcd_raw = sr[SR_W-1 -: NUM_W];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble, applied before each shift.
    always_comb begin
        sr_adj = sr;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr[BIN_W+4*d +: 4] >= 4'd5) begin
                sr_adj[BIN_W+4*d +: 4] = sr[BIN_W+4*d +: 4] + 4'd3;
            end
        end
    end

`ifdef LZ_BLANK_EN
    logic lead;

    // Blank zeros from the MS digit down; digit 0 always shown.
    always_comb begin
        bcd_out = bcd_raw;
        lead    = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (lead && bcd_raw[4*d +: 4] == 4'd0) begin
                bcd_out[4*d +: 4] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    logic unused_blank;

    assign bcd_out      = bcd_raw;
    assign unused_blank = ^BLANK_CODE;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sr     <= '0;
            cnt    <= '0;
            ovf_n  <= 1'b0;
            number <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= {NUM_W'(0), bin};
                        cnt   <= '0;
                        ovf_n <= (bin > MAX_BIN);
                    end
                end
                SHIFT: begin
                    sr  <= sr_adj << 1;
                    cnt <= cnt + CNT_W'(1);
                end
                DONE: begin
                    // Saturated value bypasses blanking on purpose.
                    number <= ovf_n ? SAT_BCD : bcd_out;
                    ovf    <= ovf_n;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq.
// Expected results are queued at acceptance and checked at done.
module tb_bin2bcd_seq;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] number;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [16:0] exp_q[$];

    bin2bcd_seq dut (
        .clk    (clk),
        .nrst   (nrst),
        .start  (start),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .number (number)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: sim time limit hit");
        $fatal(1);
    end

    // {ovf, number} reference
    function automatic logic [16:0] exp_of(input int v);
        logic [15:0] n;
        int x;
        bit lead;
        if (v > 9999) return {1'b1, 16'h9999};
        x = v;
        for (int i = 0; i < 4; i++) begin
            n[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef LZ_BLANK_EN
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lead && n[4*i +: 4] == 4'd0) n[4*i +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return {1'b0, n};
    endfunction

    task automatic accept(input int v, input bit push,
                          input logic [16:0] e);
        bin   = 14'(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        acc_cyc = cyc;
        if (push) exp_q.push_back(e);
    endtask

    task automatic wait_done(output bit ok, output int lat);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        lat = cyc - acc_cyc;
    endtask

    task automatic test_reset;
        nrst  = 1'b0;
        start = 1'b0;
        bin   = '0;
        #12;
        n_cmp++;
        if ({busy, done, ovf, number} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset: got %h want 0",
                     {busy, done, ovf, number});
        end
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        bit ok;
        int lat;
        logic [16:0] e;
        accept(1234, 1'b1, exp_of(1234));
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        wait_done(ok, lat);
        n_cmp++;
        if (!ok || lat != 15) begin
            n_bad++;
            $display("FAIL basic_lat: got %0d ok %b want 15", lat, ok);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({ovf, number} !== e) begin
            n_bad++;
            $display("FAIL basic_val: got %h want %h",
                     {ovf, number}, e);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL basic_pulse: got %b want 00", {busy, done});
        end
    endtask

    task automatic test_bounds;
        int vals[3] = '{9999, 10000, 16383};
        bit ok;
        int lat;
        logic [16:0] e;
        for (int i = 0; i < 3; i++) begin
            accept(vals[i], 1'b1, exp_of(vals[i]));
            wait_done(ok, lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || lat != 15 || {ovf, number} !== e) begin
                n_bad++;
                $display("FAIL bounds_%0d: got %h lat %0d want %h",
                         vals[i], {ovf, number}, lat, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_small;
        int vals[2] = '{0, 42};
        logic [15:0] lits[2];
        bit ok;
        int lat;
        logic [16:0] e;
`ifdef LZ_BLANK_EN
        lits[0] = 16'hFFF0;
        lits[1] = 16'hFF42;
`else
        lits[0] = 16'h0000;
        lits[1] = 16'h0042;
`endif
        for (int i = 0; i < 2; i++) begin
            accept(vals[i], 1'b1, {1'b0, lits[i]});
            wait_done(ok, lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || {ovf, number} !== e) begin
                n_bad++;
                $display("FAIL small_%0d: got %h want %h",
                         vals[i], {ovf, number}, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ignore;
        logic [16:0] prev;
        logic [16:0] e;
        bit ok;
        int lat;
        prev = {ovf, number};
        accept(5678, 1'b1, exp_of(5678));
        bin   = 14'd1111;
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({ovf, number} !== prev || done !== 1'b0) begin
                n_bad++;
                $display("FAIL ignore_hold: got %h d %b want %h",
                         {ovf, number}, done, prev);
            end
        end
        start = 1'b0;
        wait_done(ok, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || lat != 15 || {ovf, number} !== e) begin
            n_bad++;
            $display("FAIL ignore_val: got %h lat %0d want %h",
                     {ovf, number}, lat, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        bit ok;
        int lat;
        logic [16:0] e;
        accept(7, 1'b1, exp_of(7));
        wait_done(ok, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || {ovf, number} !== e) begin
            n_bad++;
            $display("FAIL b2b_first: got %h want %h",
                     {ovf, number}, e);
        end
        accept(321, 1'b1, exp_of(321));
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept: got %b want 1", busy);
        end
        wait_done(ok, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || lat != 15 || {ovf, number} !== e) begin
            n_bad++;
            $display("FAIL b2b_second: got %h lat %0d want %h",
                     {ovf, number}, lat, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int lat;
        logic [16:0] e;
        accept(8888, 1'b0, '0);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        nrst = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, ovf, number} !== 19'd0) begin
            n_bad++;
            $display("FAIL rst_mid: got %h want 0",
                     {busy, done, ovf, number});
        end
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        accept(2468, 1'b1, exp_of(2468));
        wait_done(ok, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || lat != 15 || {ovf, number} !== e) begin
            n_bad++;
            $display("FAIL rst_after: got %h lat %0d want %h",
                     {ovf, number}, lat, e);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bounds();
        test_small();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
